// File: rtl/chip_idle_ctrl_if.sv
// Signal bundle between the idle controller, its CSRs, the idle generator
// and the clock/power controller.
interface chip_idle_ctrl_if #(
  parameter int IDLE_CNT_W = 16,
  parameter int N_WAKE     = 8
);
  logic                  idle_en;
  logic [IDLE_CNT_W-1:0] idle_thresh;
  logic                  chip_is_idle;
  logic [N_WAKE-1:0]     wake_src;
  logic [N_WAKE-1:0]     wake_mask;
  logic                  gate_ack;
  logic                  gate_req;
  logic                  cpu_wake;
  logic [2:0]            idle_state;
  logic [15:0]           idle_entries;

  // Four-phase gate handshake: gate_req rises only while gate_ack is low, stays
  // high until gate_ack rises, falls only while gate_ack is high, and may not
  // rise again until gate_ack has dropped.
  modport master (
    output idle_en, idle_thresh, chip_is_idle, wake_src, wake_mask, gate_ack,
    input  gate_req, cpu_wake, idle_state, idle_entries
  );

  modport slave (
    input  idle_en, idle_thresh, chip_is_idle, wake_src, wake_mask, gate_ack,
    output gate_req, cpu_wake, idle_state, idle_entries
  );
endinterface

// File: rtl/chip_idle_ctrl.sv
// Qualifies chip idle with a dwell counter, gates the chip clock via a
// four-phase req/ack handshake, and pulses cpu_wake on the way back out.
module chip_idle_ctrl #(
  parameter int IDLE_CNT_W = 16,
  parameter int N_WAKE     = 8,
  parameter int WAKE_HOLD  = 4
) (
  input  logic           clk,
  input  logic           rst,
  chip_idle_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    RUN   = 3'd0,
    COUNT = 3'd1,
    REQ   = 3'd2,
    GATED = 3'd3,
    WAKE  = 3'd4
  } state_t;

  localparam int HOLD_W = $clog2(WAKE_HOLD + 1);

  state_t                state;
  logic [IDLE_CNT_W-1:0] cnt;
  logic                  wake_pend;
  logic [HOLD_W-1:0]     hold_cnt;
  logic                  gate_req;
  logic                  cpu_wake;
  logic [15:0]           entries;

  logic wake;
  logic leave;

  assign wake  = |(bus.wake_src & bus.wake_mask);
  assign leave = wake || !bus.idle_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      wake_pend <= 1'b0;
      hold_cnt  <= '0;
      gate_req  <= 1'b0;
      cpu_wake  <= 1'b0;
      entries   <= '0;
    end else begin
      case (state)
        RUN: begin
          cnt <= '0;
          if (bus.idle_en && bus.chip_is_idle && !wake) state <= COUNT;
        end
        COUNT: begin
          if (!bus.chip_is_idle || leave) begin
            state <= RUN;
            cnt   <= '0;
          end else if (cnt == bus.idle_thresh) begin
            state    <= REQ;
            gate_req <= 1'b1;
          end else if (cnt < bus.idle_thresh) begin
            cnt <= cnt + 1'b1;
          end
        end
        REQ: begin
          // The request cannot be withdrawn; exit requests are remembered instead.
          if (leave) wake_pend <= 1'b1;
          if (bus.gate_ack) begin
            if (entries != 16'hFFFF) entries <= entries + 16'd1;
            if (wake_pend || leave) begin
              state    <= WAKE;
              gate_req <= 1'b0;
            end else begin
              state <= GATED;
            end
          end
        end
        GATED: begin
          if (leave) begin
            state    <= WAKE;
            gate_req <= 1'b0;
          end
        end
        WAKE: begin
          gate_req <= 1'b0;
          // cpu_wake doubles as the "hold running" flag.
          if (!cpu_wake) begin
            if (!bus.gate_ack) begin
              cpu_wake <= 1'b1;
              hold_cnt <= HOLD_W'(1);
            end
          end else if (hold_cnt == HOLD_W'(WAKE_HOLD)) begin
            cpu_wake  <= 1'b0;
            hold_cnt  <= '0;
            wake_pend <= 1'b0;
            cnt       <= '0;
            state     <= RUN;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state    <= RUN;
          gate_req <= 1'b0;
          cpu_wake <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gate_req     = gate_req;
  assign bus.cpu_wake     = cpu_wake;
  assign bus.idle_state   = state;
  assign bus.idle_entries = entries;
endmodule

// File: tb/tb_chip_idle_ctrl.sv
// Directed bench for chip_idle_ctrl: entry/exit sequences, dwell aborts,
// wake during request, counter saturation and asynchronous reset.
module tb_chip_idle_ctrl;
  localparam int WAKE_HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  chip_idle_ctrl_if bus ();

  chip_idle_ctrl #(.IDLE_CNT_W(16), .N_WAKE(8), .WAKE_HOLD(WAKE_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] exp_q[$];
  int          width_q[$];
  bit          mon_en       = 1'b0;
  logic [15:0] prev_entries = '0;
  logic        prev_req     = 1'b0;
  logic        prev_ack     = 1'b0;
  logic        prev_rst     = 1'b1;
  int          hi_cnt       = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: entry-counter scoreboard, wake pulse widths, handshake order.
  always @(negedge clk) begin
    if (mon_en && bus.idle_entries !== prev_entries) begin
      if (exp_q.size() == 0) chk("entries_unexpected", {16'h0, bus.idle_entries}, {16'h0, prev_entries});
      else chk("entries_sb", {16'h0, bus.idle_entries}, {16'h0, exp_q.pop_front()});
    end
    prev_entries <= bus.idle_entries;

    if (bus.cpu_wake === 1'b1) begin
      hi_cnt <= hi_cnt + 1;
    end else if (hi_cnt != 0) begin
      if (width_q.size() == 0) chk("wake_unexpected", hi_cnt, 0);
      else chk("wake_width", hi_cnt, width_q.pop_front());
      hi_cnt <= 0;
    end

    if (!rst && !prev_rst && bus.gate_req !== prev_req)
      chk(bus.gate_req ? "req_rise_ack" : "req_fall_ack", {31'h0, prev_ack}, bus.gate_req ? 0 : 1);
    prev_req <= bus.gate_req;
    prev_ack <= bus.gate_ack;
    prev_rst <= rst;
  end

  // Short full cycle: thresh=0 entry, GATED, exit via idle_en=0, wake pulse.
  task automatic do_entry(input bit push, input logic [15:0] v);
    bus.idle_thresh  = 16'd0;
    bus.idle_en      = 1'b1;
    bus.chip_is_idle = 1'b1;
    tick(); chk("e_count", bus.idle_state, 1);
    tick(); chk("e_req", bus.idle_state, 2); chk("e_req_out", bus.gate_req, 1);
    if (push) exp_q.push_back(v);
    bus.gate_ack = 1'b1;
    tick(); chk("e_gated", bus.idle_state, 3);
    bus.chip_is_idle = 1'b0;
    bus.idle_en      = 1'b0;
    tick(); chk("e_wake", bus.idle_state, 4); chk("e_wake_req", bus.gate_req, 0);
    bus.gate_ack = 1'b0;
    width_q.push_back(WAKE_HOLD);
    repeat (WAKE_HOLD + 1) tick();
    chk("e_run", bus.idle_state, 0); chk("e_run_wake", bus.cpu_wake, 0);
    bus.idle_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.idle_en      = 1'b0;
    bus.idle_thresh  = 16'd3;
    bus.chip_is_idle = 1'b0;
    bus.wake_src     = '0;
    bus.wake_mask    = '0;
    bus.gate_ack     = 1'b0;
    repeat (3) tick();
    chk("rst_state", bus.idle_state, 0);
    chk("rst_req", bus.gate_req, 0);
    chk("rst_wake", bus.cpu_wake, 0);
    chk("rst_entries", bus.idle_entries, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Dwell of thresh+1 cycles, then request; ack two cycles later.
    bus.idle_en      = 1'b1;
    bus.chip_is_idle = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); chk("t1_count", bus.idle_state, 1); chk("t1_noreq", bus.gate_req, 0);
    end
    tick(); chk("t1_req", bus.idle_state, 2); chk("t1_req_out", bus.gate_req, 1);
    tick(); chk("t1_req_hold", bus.idle_state, 2);
    exp_q.push_back(16'd1);
    bus.gate_ack = 1'b1;
    tick(); chk("t1_gated", bus.idle_state, 3); chk("t1_gated_req", bus.gate_req, 1);
    chk("t1_entries", bus.idle_entries, 1);

    // Masked source ignored; enabled source releases the gate.
    bus.wake_mask = 8'h04;
    bus.wake_src  = 8'h10;
    tick(); chk("t3_masked", bus.idle_state, 3); chk("t3_masked_req", bus.gate_req, 1);
    bus.wake_src = 8'h04;
    tick(); chk("t3_wake", bus.idle_state, 4); chk("t3_req_drop", bus.gate_req, 0);
    bus.wake_src = 8'h00;
    width_q.push_back(WAKE_HOLD);
    tick(); chk("t3_ack_hi1", bus.cpu_wake, 0);
    tick(); chk("t3_ack_hi2", bus.cpu_wake, 0);
    bus.gate_ack = 1'b0;
    for (int i = 0; i < WAKE_HOLD; i++) begin
      tick(); chk("t3_pulse", bus.cpu_wake, 1);
    end
    bus.chip_is_idle = 1'b0;
    tick(); chk("t3_run", bus.idle_state, 0); chk("t3_pulse_end", bus.cpu_wake, 0);

    // Stray ack in RUN/COUNT is ignored; idle drop at cnt=6 aborts the dwell.
    bus.idle_thresh = 16'd10;
    bus.gate_ack    = 1'b1;
    tick(); chk("t2_stray_ack", bus.idle_state, 0); chk("t2_stray_req", bus.gate_req, 0);
    bus.chip_is_idle = 1'b1;
    tick(); chk("t2_count", bus.idle_state, 1);
    bus.gate_ack = 1'b0;
    repeat (6) tick();
    chk("t2_cnt6", bus.idle_state, 1);
    bus.chip_is_idle = 1'b0;
    tick(); chk("t2_abort", bus.idle_state, 0); chk("t2_abort_req", bus.gate_req, 0);
    bus.chip_is_idle = 1'b1;
    tick(); chk("t2_recount", bus.idle_state, 1);
    for (int i = 0; i < 10; i++) begin
      tick(); chk("t2_full_dwell", bus.idle_state, 1);
    end
    tick(); chk("t2_req", bus.idle_state, 2); chk("t2_req_out", bus.gate_req, 1);

    // Wake during REQ: held request, then straight to WAKE on ack.
    bus.wake_src = 8'h04;
    tick(); chk("t4_req_held", bus.idle_state, 2); chk("t4_req_out", bus.gate_req, 1);
    bus.wake_src = 8'h00;
    tick(); chk("t4_req_wait", bus.idle_state, 2);
    exp_q.push_back(16'd2);
    bus.gate_ack = 1'b1;
    tick(); chk("t4_direct_wake", bus.idle_state, 4); chk("t4_req_drop", bus.gate_req, 0);
    chk("t4_entries", bus.idle_entries, 2);
    bus.chip_is_idle = 1'b0;
    bus.gate_ack     = 1'b0;
    width_q.push_back(WAKE_HOLD);
    tick(); chk("t4_pulse", bus.cpu_wake, 1);
    bus.wake_src = 8'h04;
    repeat (3) tick();
    chk("t4_absorb", bus.idle_state, 4);
    bus.wake_src = 8'h00;
    tick(); chk("t4_run", bus.idle_state, 0); chk("t4_pulse_end", bus.cpu_wake, 0);

    // Saturation of the entry counter.
    mon_en = 1'b0;
    force dut.entries = 16'hFFFE;
    tick();
    release dut.entries;
    tick(); chk("t5_preload", bus.idle_entries, 16'hFFFE);
    mon_en = 1'b1;
    do_entry(1'b1, 16'hFFFF);
    chk("t5_first", bus.idle_entries, 16'hFFFF);
    do_entry(1'b0, 16'h0);
    chk("t5_saturated", bus.idle_entries, 16'hFFFF);

    // Asynchronous reset while gated with ack high.
    bus.idle_thresh  = 16'd0;
    bus.chip_is_idle = 1'b1;
    tick(); tick();
    chk("t6_req", bus.idle_state, 2);
    bus.gate_ack = 1'b1;
    tick(); chk("t6_gated", bus.idle_state, 3);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_async_state", bus.idle_state, 0);
    chk("t6_async_req", bus.gate_req, 0);
    chk("t6_async_entries", bus.idle_entries, 0);
    bus.chip_is_idle = 1'b0;
    tick();
    bus.gate_ack = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    mon_en = 1'b1;
    bus.chip_is_idle = 1'b1;
    tick(); chk("t6_one_cycle", bus.gate_req, 0);
    tick(); chk("t6_two_cycles", bus.gate_req, 1);
    exp_q.push_back(16'd1);
    bus.gate_ack = 1'b1;
    tick(); chk("t6_gated2", bus.idle_state, 3);
    bus.idle_en      = 1'b0;
    bus.chip_is_idle = 1'b0;
    tick(); chk("t6_wake", bus.idle_state, 4);
    bus.gate_ack = 1'b0;
    width_q.push_back(WAKE_HOLD);
    repeat (WAKE_HOLD + 2) tick();
    chk("t6_run", bus.idle_state, 0);
    chk("t6_entries", bus.idle_entries, 1);

    chk("sb_entries_drained", exp_q.size(), 0);
    chk("sb_wake_drained", width_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
